dsp_addsub_arbiter: RTL and testbench



---
 rtl/dsp_addsub_arbiter_if.sv | 29 ++
 rtl/dsp_addsub_arbiter.sv | 109 ++++++++++
 tb/tb_dsp_addsub_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_addsub_arbiter_if
// Requester-side request/response bundle of the shared DSP add/sub arbiter.
// Revision : 1.0
// ============================================================================
interface dsp_addsub_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  req_sub;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_sub,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sub,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/dsp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_addsub_arbiter
// Shares one pipelined DSP add/sub between ALU (0) and branch (1) requesters.
// Option   : DSP_ARB_ROUND_ROBIN_EN = round-robin, else branch has fixed priority.
// Revision : 1.0
// ============================================================================
module dsp_addsub_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  dsp_addsub_arbiter_if.slave        req,
  output logic [31:0]                dsp_input1,
  output logic [31:0]                dsp_input2,
  output logic                       dsp_addsub,
  input  logic [31:0]                dsp_out
);

  logic               w_gnt_id;
  logic               w_xfer;
  logic [LATENCY-1:0] r_tag_vld;
  logic [LATENCY-1:0] r_tag_id;
  logic [1:0]         r_rsp_valid;
  logic [31:0]        r_rsp_data;

`ifdef DSP_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_xfer) begin
      r_ptr <= ~w_gnt_id;
    end
  end

  always_comb begin
    w_gnt_id = req.req_valid[1];
    if (&req.req_valid) begin
      w_gnt_id = r_ptr;
    end
  end
`else
  always_comb begin
    w_gnt_id = req.req_valid[1];
  end
`endif

  // Flush blocks the grant, so nothing issued in a flush cycle ever enters the pipe.
  assign w_xfer        = (|req.req_valid) && !flush;
  assign req.req_ready = w_xfer ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    dsp_input1 = 32'd0;
    dsp_input2 = 32'd0;
    dsp_addsub = 1'b0;
    if (w_xfer) begin
      dsp_input1 = w_gnt_id ? req.req_a1 : req.req_a0;
      dsp_input2 = w_gnt_id ? req.req_b1 : req.req_b0;
      dsp_addsub = req.req_sub[w_gnt_id];
    end
  end

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld <= w_xfer;
          r_tag_id  <= w_gnt_id;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld <= flush ? '0 : {r_tag_vld[LATENCY-2:0], w_xfer};
          r_tag_id  <= {r_tag_id[LATENCY-2:0], w_gnt_id};
        end
      end
    end
  endgenerate

  // The operation sitting in the last stage is also in flight, so flush drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= 32'd0;
    end else begin
      r_rsp_valid <= 2'b00;
      if (r_tag_vld[LATENCY-1] && !flush) begin
        r_rsp_valid <= r_tag_id[LATENCY-1] ? 2'b10 : 2'b01;
        r_rsp_data  <= dsp_out;
      end
    end
  end

  assign req.rsp_valid = r_rsp_valid;
  assign req.rsp_data  = r_rsp_data;
  assign req.busy      = |r_tag_vld;

endmodule
`default_nettype wire

// File: tb/tb_dsp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_addsub_arbiter
// Directed + random bench with a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_dsp_addsub_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] dsp_input1;
  logic [31:0] dsp_input2;
  logic        dsp_addsub;
  logic [31:0] dsp_out;

  dsp_addsub_arbiter_if bus();

  dsp_addsub_arbiter #(.LATENCY(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req        (bus),
    .dsp_input1 (dsp_input1),
    .dsp_input2 (dsp_input2),
    .dsp_addsub (dsp_addsub),
    .dsp_out    (dsp_out)
  );

  always #5 clk = ~clk;

  // Pipelined DSP stand-in: result appears L cycles after operands.
  logic [31:0] dsp_pipe [L];
  always @(posedge clk) begin
    dsp_pipe[0] <= dsp_addsub ? dsp_input1 - dsp_input2 : dsp_input1 + dsp_input2;
    for (int i = 1; i < L; i++) dsp_pipe[i] <= dsp_pipe[i-1];
  end
  assign dsp_out = dsp_pipe[L-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t        inflight[$];
  int          cyc;
  int          n_pass;
  int          n_fail;
  int          n_total;
  logic [31:0] exp_data;
  bit          pend  [2];
  logic [31:0] opa   [2];
  logic [31:0] opb   [2];
  bit          opsub [2];
`ifdef DSP_ARB_ROUND_ROBIN_EN
  bit          favour;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = {pend[1], pend[0]};
    bus.req_a0    = opa[0];
    bus.req_b0    = opb[0];
    bus.req_a1    = opa[1];
    bus.req_b1    = opb[1];
    bus.req_sub   = {opsub[1], opsub[0]};
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [31:0] b, input bit s);
    pend[i]  = 1'b1;
    opa[i]   = a;
    opb[i]   = b;
    opsub[i] = s;
  endtask

  // One clock cycle: drive, check everything visible this cycle, advance model.
  task automatic tick(output int g);
    logic [1:0]  exp_v;
    bit          exp_busy;
    exp_t        keep[$];
    drive();
    #2;
    g = -1;
    if (!flush) begin
`ifdef DSP_ARB_ROUND_ROBIN_EN
      if (pend[0] && pend[1]) g = int'(favour);
      else if (pend[1])       g = 1;
      else if (pend[0])       g = 0;
`else
      if (pend[1])      g = 1;
      else if (pend[0]) g = 0;
`endif
    end
    check("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check("dsp_input1", dsp_input1, (g < 0) ? 32'd0 : opa[g]);
    check("dsp_input2", dsp_input2, (g < 0) ? 32'd0 : opb[g]);
    check("dsp_addsub", 32'(dsp_addsub), (g < 0) ? 32'd0 : 32'(opsub[g]));

    exp_v    = 2'b00;
    exp_busy = 1'b0;
    foreach (inflight[k]) begin
      if (inflight[k].due == cyc) begin
        exp_v    = 2'b01 << inflight[k].id;
        exp_data = inflight[k].data;
      end
      if (inflight[k].due - L <= cyc && cyc < inflight[k].due) exp_busy = 1'b1;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
    check("rsp_data", bus.rsp_data, exp_data);
    check("busy", 32'(bus.busy), 32'(exp_busy));

    foreach (inflight[k]) if (inflight[k].due > cyc) keep.push_back(inflight[k]);
    inflight = keep;
    if (flush) inflight.delete();
    if (g >= 0) begin
      inflight.push_back('{cyc + L + 1, g, opsub[g] ? opa[g] - opb[g] : opa[g] + opb[g]});
      pend[g] = 1'b0;
`ifdef DSP_ARB_ROUND_ROBIN_EN
      favour = (g == 0);
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int g;
    for (int n = 0; n < 60 && (pend[0] || pend[1] || inflight.size() != 0); n++) tick(g);
    check("drain", 32'(inflight.size()) + 32'(pend[0]) + 32'(pend[1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int exp_gnt [4];
    cyc = 0; n_pass = 0; n_fail = 0; n_total = 0; exp_data = 32'd0;
    for (int i = 0; i < 2; i++) begin pend[i] = 0; opa[i] = 0; opb[i] = 0; opsub[i] = 0; end
`ifdef DSP_ARB_ROUND_ROBIN_EN
    favour = 1'b0;
`endif
    drive();
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Single add 5+3 from requester 0
    req(0, 32'h5, 32'h3, 1'b0);
    tick(g); tick(g); tick(g);
    check("single_add_data", bus.rsp_data, 32'h8);
    check("single_add_valid", 32'(bus.rsp_valid), 32'h1);
    drain();

    // Subtract wrap 0-1 from requester 1
    req(1, 32'h0, 32'h1, 1'b1);
    tick(g); tick(g); tick(g);
    check("sub_wrap_data", bus.rsp_data, 32'hFFFF_FFFF);
    check("sub_wrap_valid", 32'(bus.rsp_valid), 32'h2);
    drain();

    // Asynchronous reset between edges while an op is in flight
    req(0, 32'h7, 32'h9, 1'b0);
    tick(g);
    #2;
    reset = 1'b1;
    #1;
    check("areset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("areset_busy", 32'(bus.busy), 32'd0);
    check("areset_rsp_data", bus.rsp_data, 32'd0);
    inflight.delete();
    exp_data = 32'd0;
`ifdef DSP_ARB_ROUND_ROBIN_EN
    favour = 1'b0;
`endif
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;

    // Contention from reset: both requesters continuously valid for 4 cycles
`ifdef DSP_ARB_ROUND_ROBIN_EN
    exp_gnt = '{0, 1, 0, 1};
`else
    exp_gnt = '{1, 1, 1, 1};
`endif
    req(0, 32'd10, 32'd1, 1'b0);
    req(1, 32'd20, 32'd2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(g);
      check($sformatf("contend_gnt%0d", k), 32'(g), 32'(exp_gnt[k]));
      if (g >= 0) req(g, 32'(100 * k + 5), 32'(k), 1'(k));
    end
    drain();

    // Back-to-back issue from requester 0
    req(0, 32'd1, 32'd1, 1'b0); tick(g);
    req(0, 32'd2, 32'd2, 1'b0); tick(g);
    req(0, 32'd3, 32'd3, 1'b0); tick(g);
    check("b2b_first", bus.rsp_data, 32'd2);
    tick(g);
    check("b2b_second", bus.rsp_data, 32'd4);
    tick(g);
    check("b2b_third", bus.rsp_data, 32'd6);
    drain();

    // Flush: issue at T, flush at T+1, pending request completes from T+2
    req(0, 32'd100, 32'd1, 1'b0); tick(g);
    req(1, 32'd200, 32'd2, 1'b0);
    flush = 1'b1; tick(g);
    flush = 1'b0; tick(g);
    check("flush_regrant", 32'(g), 32'd1);
    drain();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0)
          req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      tick(g);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
